piece_motion_controller: RTL
============================

# piece_motion_controller

Sequential owner of the falling piece's position: consumes `left_collision`, `right_collision` and `down_collision` from `piece_collision_checker`, and drives that checker's `piece_x`, `piece_y` and `no_piece`. It turns player move requests and gravity ticks into one-cell moves, then runs the spawn and lock handshakes with the piece generator and the board writer. It sits between the input/tick logic and the board-state update stage in the GAME clock domain.

## Interface
Parameters:
- `BOARD_WIDTH`, default 10: board columns.
- `BOARD_HEIGHT`, default 20: board rows.
- `GRAVITY_TICKS`, default 30: `game_tick` pulses per gravity step, ≥1.
- `SPAWN_X`, default 3: `piece_x` loaded at spawn.

Ports:
- `clk`  in  1  game clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `game_tick`  in  1  one-cycle frame pulse.
- `move_left_req`, `move_right_req`, `soft_drop_req`, `hard_drop_req`  in  1 each  one-cycle request pulses.
- `left_collision`, `right_collision`, `down_collision`  in  1 each  combinational from the checker; always reflect the current outputs.
- `spawn_ack`  in  1  generator has presented a new `piece_grid`.
- `lock_ack`  in  1  board writer has merged the piece.
- `piece_x`  out  $clog2(BOARD_WIDTH)  piece column (4×4 grid origin).
- `piece_y`  out  $clog2(BOARD_HEIGHT)  piece row, 0 = top.
- `no_piece`  out  1  no live piece.
- `spawn_req`  out  1  level; request a new piece.
- `lock_req`  out  1  level; commit the piece at `piece_x`/`piece_y`.
- `game_over`  out  1  sticky top-out flag.

## Operation
- States: SPAWN, SETTLE, ACTIVE, HARD_DROP, LOCK, OVER.
- Reset values: state SPAWN, `piece_x`=SPAWN_X, `piece_y`=0, `no_piece`=1, `spawn_req`=0, `lock_req`=0, `game_over`=0. The gravity counter and gravity-pending flag reset to 0.
- SPAWN:
  - `no_piece`=1; `piece_x`=SPAWN_X; `piece_y`=0.
  - `spawn_req`=1 from the cycle after reset or entry, held until `spawn_ack`.
  - On `spawn_ack`: go to SETTLE, `no_piece`←0, `spawn_req`←0.
- SETTLE: exactly one cycle, so the collision flags reflect the new grid. Then go to ACTIVE.
- ACTIVE, gravity:
  - Each `game_tick` increments the counter.
  - At count GRAVITY_TICKS−1 with a tick: counter←0 and pending←1.
- ACTIVE, one action per cycle, by priority:
  1. `hard_drop_req`: go to HARD_DROP.
  2. `soft_drop_req` or pending: clear pending and counter. If `down_collision` or `piece_y`==BOARD_HEIGHT−1, go to LOCK; otherwise `piece_y`+1.
  3. `move_left_req` XOR `move_right_req`: move one column only if that side's collision flag is 0 and there is no boundary. Boundaries: `piece_x`==0 blocks left; `piece_x`==BOARD_WIDTH−1 blocks right. No wrap.
  4. Left and right requested together: both are dropped.
- HARD_DROP:
  - Each cycle: if `down_collision` or the floor row is reached, go to LOCK; otherwise `piece_y`+1.
  - All requests and ticks are ignored.
- LOCK:
  - `lock_req`=1; `piece_x`/`piece_y` frozen; `no_piece` stays 0 until ack.
  - On `lock_ack`: `lock_req`←0 and `no_piece`←1. If `piece_y`==0, go to OVER; otherwise go to SPAWN.
- OVER: `game_over`=1 and `no_piece`=1; the state is terminal until `reset`.
- Requests arriving outside ACTIVE are discarded, not queued.
- The gravity counter and pending flag are held at 0 outside ACTIVE.

## Timing
- All outputs are registered.
- A move accepted in cycle N is visible in cycle N+1. Collision flags for the new position are valid in N+1.
- A blocked move changes nothing, and the blocking request is consumed.
- `spawn_ack` and `lock_ack` may arrive in the same cycle as the request rises or any later cycle. The controller samples them only in SPAWN and LOCK respectively.
- An ack sampled in cycle N takes effect in N+1.
- Gravity: from ACTIVE entry with no other activity, the first gravity step occurs in the cycle after the GRAVITY_TICKS-th `game_tick`.
- Hard drop from row r landing at row k: `piece_y` reaches k after k−r cycles in HARD_DROP; `lock_req` rises one cycle later.
- Asynchronous reset mid-handshake drops `spawn_req`/`lock_req` immediately. The next `spawn_req` rises on the first clock after release.

## Test plan
- Reset release, `spawn_ack` 3 cycles later → `spawn_req` high in cycles 1–3; `no_piece` falls in cycle 4; ACTIVE in cycle 5; `piece_x`=3, `piece_y`=0.
- ACTIVE at x=3: 3 `move_left_req` pulses with flags clear → x=0. A 4th pulse → x stays 0. `left_collision`=1 then blocks a right→left sequence at x=1.
- GRAVITY_TICKS=2, 4 ticks and no flags → `piece_y` 0→2. Force `down_collision`=1 at the next step → `lock_req`=1, y held at 2. `lock_ack` → `no_piece`=1, back to SPAWN.
- `hard_drop_req` at y=0 with `down_collision` asserted once y=17 → y increments each cycle to 17; `lock_req` rises in the following cycle; lateral pulses during the drop are ignored.
- Lock at y=0 followed by `lock_ack` → `game_over`=1, `no_piece`=1, `spawn_req` stays 0; `reset` clears all of these.
- `move_left_req` and `move_right_req` in the same cycle → x unchanged. `soft_drop_req` plus `move_left_req` together → only y+1 occurs.

Source files
------------

// File: rtl/piece_motion_if.sv
// ============================================================================
// piece_motion_if : handshake and position signals of the piece controller
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface piece_motion_if #(
  parameter int BOARD_WIDTH  = 10,
  parameter int BOARD_HEIGHT = 20
);
  localparam int X_W = $clog2(BOARD_WIDTH);
  localparam int Y_W = $clog2(BOARD_HEIGHT);

  logic           game_tick;
  logic           move_left_req;
  logic           move_right_req;
  logic           soft_drop_req;
  logic           hard_drop_req;
  logic           left_collision;
  logic           right_collision;
  logic           down_collision;
  logic           spawn_ack;
  logic           lock_ack;
  logic [X_W-1:0] piece_x;
  logic [Y_W-1:0] piece_y;
  logic           no_piece;
  logic           spawn_req;
  logic           lock_req;
  logic           game_over;

  modport master (
    input  game_tick, move_left_req, move_right_req, soft_drop_req, hard_drop_req,
    input  left_collision, right_collision, down_collision, spawn_ack, lock_ack,
    output piece_x, piece_y, no_piece, spawn_req, lock_req, game_over
  );

  modport slave (
    output game_tick, move_left_req, move_right_req, soft_drop_req, hard_drop_req,
    output left_collision, right_collision, down_collision, spawn_ack, lock_ack,
    input  piece_x, piece_y, no_piece, spawn_req, lock_req, game_over
  );
endinterface

`default_nettype wire

// File: rtl/piece_motion_controller.sv
// ============================================================================
// piece_motion_controller : falling-piece position, gravity, spawn/lock FSM
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module piece_motion_controller #(
  parameter int BOARD_WIDTH   = 10,
  parameter int BOARD_HEIGHT  = 20,
  parameter int GRAVITY_TICKS = 30,
  parameter int SPAWN_X       = 3
) (
  input  wire               clk,
  input  wire               reset,
  piece_motion_if.master    bus
);

  localparam int X_W   = $clog2(BOARD_WIDTH);
  localparam int Y_W   = $clog2(BOARD_HEIGHT);
  localparam int CNT_W = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS) : 1;

  localparam logic [X_W-1:0]   X_MAX   = X_W'(BOARD_WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_MAX   = Y_W'(BOARD_HEIGHT - 1);
  localparam logic [X_W-1:0]   X_SPAWN = X_W'(SPAWN_X);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GRAVITY_TICKS - 1);

  typedef enum logic [2:0] {
    S_SPAWN     = 3'd0,
    S_SETTLE    = 3'd1,
    S_ACTIVE    = 3'd2,
    S_HARD_DROP = 3'd3,
    S_LOCK      = 3'd4,
    S_OVER      = 3'd5
  } state_t;

  state_t           state;
  logic [X_W-1:0]   piece_x;
  logic [Y_W-1:0]   piece_y;
  logic             no_piece;
  logic             spawn_req;
  logic             lock_req;
  logic             game_over;
  logic [CNT_W-1:0] grav_cnt;
  logic             grav_pend;

  logic at_bottom;
  logic go_left;
  logic go_right;

  assign at_bottom = bus.down_collision || (piece_y == Y_MAX);
  assign go_left   = bus.move_left_req && !bus.move_right_req;
  assign go_right  = bus.move_right_req && !bus.move_left_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_SPAWN;
      piece_x   <= X_SPAWN;
      piece_y   <= '0;
      no_piece  <= 1'b1;
      spawn_req <= 1'b0;
      lock_req  <= 1'b0;
      game_over <= 1'b0;
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
    end else begin
      // Gravity state only lives in ACTIVE; every other state forces it to 0.
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
      case (state)
        S_SPAWN: begin
          no_piece <= 1'b1;
          piece_x  <= X_SPAWN;
          piece_y  <= '0;
          if (bus.spawn_ack) begin
            state     <= S_SETTLE;
            no_piece  <= 1'b0;
            spawn_req <= 1'b0;
          end else begin
            spawn_req <= 1'b1;
          end
        end

        S_SETTLE: state <= S_ACTIVE;

        S_ACTIVE: begin
          grav_cnt  <= grav_cnt;
          grav_pend <= grav_pend;
          if (bus.game_tick) begin
            if (grav_cnt == CNT_MAX) begin
              grav_cnt  <= '0;
              grav_pend <= 1'b1;
            end else begin
              grav_cnt <= grav_cnt + CNT_W'(1);
            end
          end
          if (bus.hard_drop_req) begin
            state     <= S_HARD_DROP;
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
          end else if (bus.soft_drop_req || grav_pend) begin
            // A step consumes the pending gravity and restarts the count.
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
            if (at_bottom) begin
              state    <= S_LOCK;
              lock_req <= 1'b1;
            end else begin
              piece_y <= piece_y + Y_W'(1);
            end
          end else if (go_left) begin
            if (!bus.left_collision && piece_x != '0)
              piece_x <= piece_x - X_W'(1);
          end else if (go_right) begin
            if (!bus.right_collision && piece_x != X_MAX)
              piece_x <= piece_x + X_W'(1);
          end
        end

        S_HARD_DROP: begin
          if (at_bottom) begin
            state    <= S_LOCK;
            lock_req <= 1'b1;
          end else begin
            piece_y <= piece_y + Y_W'(1);
          end
        end

        S_LOCK: begin
          if (bus.lock_ack) begin
            lock_req <= 1'b0;
            no_piece <= 1'b1;
            if (piece_y == '0) begin
              state     <= S_OVER;
              game_over <= 1'b1;
            end else begin
              state   <= S_SPAWN;
              piece_x <= X_SPAWN;
              piece_y <= '0;
            end
          end
        end

        S_OVER: begin
          game_over <= 1'b1;
          no_piece  <= 1'b1;
        end

        default: state <= S_SPAWN;
      endcase
    end
  end

  assign bus.piece_x   = piece_x;
  assign bus.piece_y   = piece_y;
  assign bus.no_piece  = no_piece;
  assign bus.spawn_req = spawn_req;
  assign bus.lock_req  = lock_req;
  assign bus.game_over = game_over;

endmodule

`default_nettype wire
